// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_pkg
// Description : Shared types for the age-ordered issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_pkg;

    localparam int unsigned c_preg_w = 6;

    typedef logic [c_preg_w-1:0] preg_addr_t;

    typedef struct packed {
        logic        src1_ready;
        preg_addr_t  src1_pid;
        logic        src2_ready;
        preg_addr_t  src2_pid;
        preg_addr_t  dst;
        logic [7:0]  ctl;
        logic [31:0] imm;
        logic [31:0] pc;
    } iq_entry_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t pid;
    } wake_req_t;

    function automatic logic entry_ready(input iq_entry_t e);
        return e.src1_ready & e.src2_ready;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_age_select.sv
`default_nettype none
// ============================================================================
// Module      : iq_age_select
// Description : Picks up to ISSUE_WIDTH oldest ready entries from an age matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_age_select #(
    parameter int unsigned QLEN        = 8,
    parameter int unsigned ISSUE_WIDTH = 2
) (
    input  logic [QLEN-1:0][QLEN-1:0]        i_age,
    input  logic [QLEN-1:0]                  i_ready,
    output logic [ISSUE_WIDTH-1:0][QLEN-1:0] o_grant
);

    localparam int unsigned c_rank_w = $clog2(QLEN + 1);

    logic [QLEN-1:0][c_rank_w-1:0] w_rank;

    // i_age[j][i] set means entry j is older than entry i; an entry's rank is
    // the number of ready entries older than it, so port p takes rank p.
    always_comb begin
        w_rank  = '0;
        o_grant = '0;
        for (int i = 0; i < QLEN; i++) begin
            for (int j = 0; j < QLEN; j++) begin
                if (i_ready[j] && i_age[j][i]) begin
                    w_rank[i] = w_rank[i] + c_rank_w'(1);
                end
            end
        end
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < QLEN; i++) begin
                if (i_ready[i] && (w_rank[i] == c_rank_w'(p))) begin
                    o_grant[p][i] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/age_iqueue.sv
`default_nettype none
// ============================================================================
// Module      : age_iqueue
// Description : Out-of-order issue queue with wakeup and age-matrix selection.
// Revision    : 1.0 - initial release
// ============================================================================
module age_iqueue
    import issue_pkg::*;
#(
    parameter int unsigned QLEN        = 8,
    parameter int unsigned WRITE_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned WAKE_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [WRITE_WIDTH-1:0]         in_valid,
    input  iq_entry_t [WRITE_WIDTH-1:0]    in_entry,
    output logic                           in_ready,
    input  logic [WAKE_WIDTH-1:0]          wake_valid,
    input  preg_addr_t [WAKE_WIDTH-1:0]    wake_pid,
    input  logic                           stall,
    output logic [ISSUE_WIDTH-1:0]         out_valid,
    output iq_entry_t [ISSUE_WIDTH-1:0]    out_entry,
    output logic [$clog2(QLEN+1)-1:0]      free_cnt
);

    localparam int unsigned c_idx_w = (QLEN > 1) ? $clog2(QLEN) : 1;
    localparam int unsigned c_cnt_w = $clog2(QLEN + 1);

    logic [QLEN-1:0]                    valid_q, valid_d;
    iq_entry_t [QLEN-1:0]               entry_q, entry_d;
    logic [QLEN-1:0][QLEN-1:0]          age_q, age_d;

    wake_req_t [WAKE_WIDTH-1:0]         w_wake;
    logic [QLEN-1:0]                    w_ready;
    logic [ISSUE_WIDTH-1:0][QLEN-1:0]   w_grant;
    logic [WRITE_WIDTH-1:0]             w_wr_en;
    logic [WRITE_WIDTH-1:0][c_idx_w-1:0] w_wr_idx;
    logic [c_cnt_w-1:0]                 w_free_cnt;

    generate
        for (genvar k = 0; k < WAKE_WIDTH; k++) begin : g_wake
            assign w_wake[k] = {wake_valid[k], wake_pid[k]};
        end
    endgenerate

    function automatic iq_entry_t apply_wake(input iq_entry_t e,
                                             input wake_req_t [WAKE_WIDTH-1:0] w);
        iq_entry_t r;
        r = e;
        for (int k = 0; k < WAKE_WIDTH; k++) begin
            if (w[k].valid && (w[k].pid == r.src1_pid)) r.src1_ready = 1'b1;
            if (w[k].valid && (w[k].pid == r.src2_pid)) r.src2_ready = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        w_ready    = '0;
        w_free_cnt = '0;
        for (int i = 0; i < QLEN; i++) begin
            w_ready[i] = valid_q[i] & entry_ready(entry_q[i]);
            if (!valid_q[i]) w_free_cnt = w_free_cnt + c_cnt_w'(1);
        end
    end

    assign free_cnt = w_free_cnt;
    assign in_ready = (32'(w_free_cnt) >= WRITE_WIDTH);

    // Each valid slot takes the lowest-numbered entry still free after the
    // slots before it; only entries empty in registered state are eligible.
    always_comb begin
        logic [QLEN-1:0] avail;
        avail    = ~valid_q;
        w_wr_en  = '0;
        w_wr_idx = '0;
        for (int s = 0; s < WRITE_WIDTH; s++) begin
            if (in_ready && in_valid[s]) begin
                for (int i = QLEN - 1; i >= 0; i--) begin
                    if (avail[i]) begin
                        w_wr_idx[s] = c_idx_w'(i);
                        w_wr_en[s]  = 1'b1;
                    end
                end
                avail[w_wr_idx[s]] = 1'b0;
            end
        end
    end

    iq_age_select #(
        .QLEN        (QLEN),
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_select (
        .i_age   (age_q),
        .i_ready (w_ready),
        .o_grant (w_grant)
    );

    always_comb begin
        out_valid = '0;
        out_entry = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < QLEN; i++) begin
                if (w_grant[p][i]) begin
                    out_valid[p] = 1'b1;
                    out_entry[p] = entry_q[i];
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        age_d   = age_q;
        for (int i = 0; i < QLEN; i++) begin
            entry_d[i] = apply_wake(entry_q[i], w_wake);
        end
        if (!stall) begin
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                for (int i = 0; i < QLEN; i++) begin
                    if (w_grant[p][i]) valid_d[i] = 1'b0;
                end
            end
        end
        // A new entry is younger than everything; same-cycle writes are then
        // reordered among themselves by slot index.
        for (int s = 0; s < WRITE_WIDTH; s++) begin
            if (w_wr_en[s]) begin
                valid_d[w_wr_idx[s]] = 1'b1;
                entry_d[w_wr_idx[s]] = apply_wake(in_entry[s], w_wake);
                for (int j = 0; j < QLEN; j++) begin
                    age_d[j][w_wr_idx[s]] = 1'b1;
                    age_d[w_wr_idx[s]][j] = 1'b0;
                end
            end
        end
        for (int s = 0; s < WRITE_WIDTH; s++) begin
            for (int t = 0; t < WRITE_WIDTH; t++) begin
                if (w_wr_en[s] && w_wr_en[t]) begin
                    age_d[w_wr_idx[s]][w_wr_idx[t]] = (s < t);
                end
            end
        end
        if (flush) begin
            valid_d = '0;
            age_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
        entry_q <= entry_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_age_iqueue.sv
`default_nettype none
// ============================================================================
// Module      : tb_age_iqueue
// Description : Directed and random checks of age_iqueue against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_age_iqueue;
    import issue_pkg::*;

    localparam int QLEN = 8;
    localparam int WW   = 4;
    localparam int IW   = 2;
    localparam int KW   = 4;

    logic                         clk;
    logic                         reset;
    logic                         flush;
    logic [WW-1:0]                in_valid;
    iq_entry_t [WW-1:0]           in_entry;
    logic                         in_ready;
    logic [KW-1:0]                wake_valid;
    preg_addr_t [KW-1:0]          wake_pid;
    logic                         stall;
    logic [IW-1:0]                out_valid;
    iq_entry_t [IW-1:0]           out_entry;
    logic [$clog2(QLEN+1)-1:0]    free_cnt;

    age_iqueue #(
        .QLEN        (QLEN),
        .WRITE_WIDTH (WW),
        .ISSUE_WIDTH (IW),
        .WAKE_WIDTH  (KW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_entry   (in_entry),
        .in_ready   (in_ready),
        .wake_valid (wake_valid),
        .wake_pid   (wake_pid),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_entry  (out_entry),
        .free_cnt   (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: resident entries held oldest-first.
    iq_entry_t mq[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic iq_entry_t mk(input logic [31:0] pc, input logic r1, input int p1,
                                     input logic r2, input int p2);
        iq_entry_t e;
        e.src1_ready = r1;
        e.src1_pid   = preg_addr_t'(p1);
        e.src2_ready = r2;
        e.src2_pid   = preg_addr_t'(p2);
        e.dst        = preg_addr_t'($urandom);
        e.ctl        = 8'($urandom);
        e.imm        = $urandom;
        e.pc         = pc;
        return e;
    endfunction

    function automatic iq_entry_t woken(input iq_entry_t e);
        iq_entry_t r;
        r = e;
        for (int k = 0; k < KW; k++) begin
            if (wake_valid[k] && wake_pid[k] == r.src1_pid) r.src1_ready = 1'b1;
            if (wake_valid[k] && wake_pid[k] == r.src2_pid) r.src2_ready = 1'b1;
        end
        return r;
    endfunction

    task automatic check_outputs();
        int n;
        logic [IW-1:0] exp_v;
        iq_entry_t exp_e [IW];
        n     = 0;
        exp_v = '0;
        for (int p = 0; p < IW; p++) exp_e[p] = '0;
        foreach (mq[i]) begin
            if (n < IW && mq[i].src1_ready && mq[i].src2_ready) begin
                exp_v[n] = 1'b1;
                exp_e[n] = mq[i];
                n++;
            end
        end
        chk("free_cnt", 128'(free_cnt), 128'(QLEN - mq.size()));
        chk("in_ready", 128'(in_ready), 128'((QLEN - mq.size()) >= WW));
        for (int p = 0; p < IW; p++) begin
            chk($sformatf("out_valid[%0d]", p), 128'(out_valid[p]), 128'(exp_v[p]));
            if (exp_v[p]) chk($sformatf("out_entry[%0d]", p), 128'(out_entry[p]), 128'(exp_e[p]));
        end
    endtask

    task automatic model_update();
        iq_entry_t nq[$];
        int issued;
        bit can_enq;
        issued  = 0;
        can_enq = ((QLEN - mq.size()) >= WW);
        if (reset || flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) begin
                if (!stall && mq[i].src1_ready && mq[i].src2_ready && issued < IW) begin
                    issued++;
                end else begin
                    nq.push_back(woken(mq[i]));
                end
            end
            if (can_enq) begin
                for (int s = 0; s < WW; s++) begin
                    if (in_valid[s]) nq.push_back(woken(in_entry[s]));
                end
            end
            mq = nq;
        end
    endtask

    task automatic idle();
        reset      = 1'b0;
        flush      = 1'b0;
        stall      = 1'b0;
        in_valid   = '0;
        in_entry   = '0;
        wake_valid = '0;
        wake_pid   = '0;
    endtask

    task automatic enq(input int s, input iq_entry_t e);
        in_valid[s] = 1'b1;
        in_entry[s] = e;
    endtask

    task automatic tick();
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_update();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle();

        // Four ready entries, issued two per cycle in age order
        for (int s = 0; s < WW; s++) enq(s, mk(32'h100 + 32'(4 * s), 1'b1, 0, 1'b1, 0));
        tick();
        idle();
        tick();
        tick();
        tick();

        // Wakeup of pid 5 makes both entries issuable only the cycle after
        enq(0, mk(32'h200, 1'b0, 5, 1'b1, 1));
        enq(1, mk(32'h204, 1'b0, 5, 1'b1, 2));
        tick();
        idle();
        tick();
        tick();
        wake_valid[2] = 1'b1;
        wake_pid[2]   = preg_addr_t'(5);
        tick();
        idle();
        tick();
        tick();

        // Wakeup in the same cycle as enqueue is not lost
        enq(0, mk(32'h300, 1'b1, 3, 1'b0, 7));
        wake_valid[1] = 1'b1;
        wake_pid[1]   = preg_addr_t'(7);
        tick();
        idle();
        tick();
        tick();

        // Fill the queue, drop an enqueue while full, then drain
        for (int s = 0; s < WW; s++) enq(s, mk(32'h400 + 32'(4 * s), 1'b0, 40, 1'b1, 1));
        tick();
        idle();
        for (int s = 0; s < WW; s++) enq(s, mk(32'h410 + 32'(4 * s), 1'b0, 40, 1'b1, 1));
        tick();
        idle();
        for (int s = 0; s < WW; s++) enq(s, mk(32'h420 + 32'(4 * s), 1'b1, 1, 1'b1, 1));
        tick();
        idle();
        wake_valid[0] = 1'b1;
        wake_pid[0]   = preg_addr_t'(40);
        tick();
        idle();
        for (int c = 0; c < 5; c++) tick();

        // Stall holds the selection and frees nothing
        enq(0, mk(32'h500, 1'b1, 1, 1'b1, 1));
        enq(2, mk(32'h504, 1'b1, 1, 1'b1, 1));
        tick();
        idle();
        stall = 1'b1;
        tick();
        tick();
        tick();
        stall = 1'b0;
        tick();
        tick();

        // Flush beats simultaneous enqueue and wakeup
        for (int s = 0; s < WW; s++) enq(s, mk(32'h600 + 32'(4 * s), 1'b0, 50, 1'b1, 1));
        tick();
        idle();
        enq(0, mk(32'h610, 1'b0, 50, 1'b1, 1));
        enq(1, mk(32'h614, 1'b0, 50, 1'b1, 1));
        tick();
        idle();
        flush = 1'b1;
        for (int s = 0; s < WW; s++) enq(s, mk(32'h620 + 32'(4 * s), 1'b1, 1, 1'b1, 1));
        wake_valid[3] = 1'b1;
        wake_pid[3]   = preg_addr_t'(50);
        tick();
        idle();
        tick();

        // Reset mid-operation discards resident entries
        for (int s = 0; s < WW; s++) enq(s, mk(32'h700 + 32'(4 * s), 1'b1, 1, 1'b1, 1));
        tick();
        idle();
        reset = 1'b1;
        tick();
        idle();
        tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int s = 0; s < WW; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    enq(s, mk($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                              1'($urandom_range(0, 1)), int'($urandom_range(0, 15))));
                end
            end
            for (int k = 0; k < KW; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    wake_valid[k] = 1'b1;
                    wake_pid[k]   = preg_addr_t'($urandom_range(0, 15));
                end
            end
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle();
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/age_iqueue.md
AGE_IQUEUE -- requirements
Module: age_iqueue

Interface
REQ-001 SHALL take parameter QLEN, default 8, number of queue entries (power of two not required, >= ISSUE_WIDTH).
REQ-002 SHALL take parameter WRITE_WIDTH, default 4, enqueue slots per cycle.
REQ-003 SHALL take parameter ISSUE_WIDTH, default 2, issue ports per cycle.
REQ-004 SHALL take parameter WAKE_WIDTH, default 4, wakeup broadcast ports.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port flush, input, 1, discard all entries.
REQ-008 SHALL have port in_valid, input, WRITE_WIDTH, per-slot enqueue request.
REQ-009 SHALL have port in_entry, input, WRITE_WIDTH x iq_entry_t, enqueue payload (src1/src2 ready+pid, dst, ctl, imm, pc).
REQ-010 SHALL have port in_ready, output, 1, queue can accept WRITE_WIDTH entries this cycle.
REQ-011 SHALL have port wake_valid, input, WAKE_WIDTH, wakeup broadcast valid.
REQ-012 SHALL have port wake_pid, input, WAKE_WIDTH x preg_addr_t, woken physical register.
REQ-013 SHALL have port stall, input, 1, downstream cannot accept issue this cycle.
REQ-014 SHALL have port out_valid, output, ISSUE_WIDTH, issue port carries an entry.
REQ-015 SHALL have port out_entry, output, ISSUE_WIDTH x iq_entry_t, issued entry.
REQ-016 SHALL have port free_cnt, output, $clog2(QLEN+1), number of empty entries.

Function
REQ-017 in_ready SHALL be 1 iff free_cnt >= WRITE_WIDTH; enqueue is all-or-nothing: when in_ready=0 no slot is written.
REQ-018 When in_ready=1, each slot with in_valid=1 SHALL be written into a distinct free entry at the edge; invalid slots consume nothing.
REQ-019 Slots written in the same cycle SHALL be age-ordered by slot index (lower index older); all are younger than every resident entry.
REQ-020 Age SHALL be tracked with a QLEN x QLEN age matrix updated on enqueue; no sequence counter wrap-around.
REQ-021 An entry SHALL be ready when both src ready bits are 1; ready is computed from registered state only.
REQ-022 On a cycle with wake_valid[k]=1, any resident entry source with pid == wake_pid[k] SHALL set its ready bit at the edge.
REQ-023 Wake matching SHALL also apply to entries being enqueued in the same cycle (write-port bypass), so no wakeup is lost.
REQ-024 Select SHALL choose up to ISSUE_WIDTH oldest ready entries; port 0 carries the oldest, port 1 the next, etc.
REQ-025 out_valid/out_entry SHALL be combinational from registered state; minimum latency enqueue-to-issue = 1 cycle (written edge N, issuable cycle N+1).
REQ-026 Wake at cycle N SHALL make the entry issuable at cycle N+1, never in cycle N.
REQ-027 When stall=0, entries presented with out_valid=1 SHALL be freed at the edge; freed entries count toward free_cnt from the next cycle.
REQ-028 When stall=1, out_valid SHALL still reflect selection, but no entry is freed and selection repeats next cycle.
REQ-029 free_cnt SHALL equal QLEN minus resident entries, updated with both enqueue and issue in the same edge.
REQ-030 flush SHALL invalidate all entries at the edge, overriding simultaneous enqueue, issue and wake; free_cnt = QLEN next cycle.
REQ-031 With no ready entry, all out_valid SHALL be 0; with empty queue, free_cnt = QLEN.

Reset
REQ-032 reset SHALL clear all entry valid bits and age matrix at the edge, overriding flush, enqueue and wake.
REQ-033 After reset: in_ready=1 (for WRITE_WIDTH <= QLEN), out_valid=0, free_cnt=QLEN; out_entry don't-care when invalid.
REQ-034 reset asserted mid-operation SHALL discard in-flight entries; nothing issues in the cycle after reset.

Structure
REQ-035 iq_entry_t, preg_addr_t and wake_req_t SHALL live in issue_pkg; QLEN/widths remain module parameters.
REQ-036 Oldest-ready selection SHALL be a sub-module iq_age_select (age matrix + ready vector -> ISSUE_WIDTH one-hot grants).

Verification
REQ-037 Reset, then enqueue 4 ready entries pc 0x100..0x10c -> cycle+1 out 0x100/0x104, cycle+2 0x108/0x10c, free_cnt returns to 8.
REQ-038 Enqueue 2 entries with src1 pid 5 not ready; wake pid 5 at cycle 3 -> both issue in cycle 4, not cycle 3.
REQ-039 Enqueue with src pid 7 not ready while wake_pid=7 same cycle -> entry issues next cycle (bypass).
REQ-040 Fill to free_cnt=4, enqueue 4 -> accepted, free_cnt=0, in_ready=0; further enqueue dropped; issue 2 with stall=0 -> free_cnt=2.
REQ-041 Hold stall=1 for 3 cycles with 2 ready entries -> same two out_entry each cycle, free_cnt unchanged; release -> freed.
REQ-042 Assert flush with simultaneous enqueue and wake on 6 resident entries -> next cycle out_valid=0, free_cnt=8.
